weight_load_ctrl: RTL and testbench

Sequencer for the per-column weight FIFO array of the CNN accelerator. It accepts 32-bit weight words from the AXI-side stream and steers each word into one column FIFO via one-hot `fifo_en`. It then drives the column output enables `out_en` with a one-cycle-per-column skew so weights enter the systolic PE grid diagonally. It sits between the AXI weight interface and the weight array, and reports completion to the layer scheduler.

---
 rtl/weight_ctrl_pkg.sv | 29 ++
 rtl/weight_load_ctrl_if.sv | 44 ++++
 rtl/pe_en_skew.sv | 63 ++++++
 rtl/weight_load_ctrl.sv | 175 +++++++++++++++++
 tb/tb_weight_load_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/weight_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : weight_ctrl_pkg
// Description : Shared types, widths and helpers for the weight load
//               controller (FSM state type, field widths, K*K helper).
// Revision    : 1.0 - initial release
// ============================================================================
package weight_ctrl_pkg;

  localparam int WORD_W = 32;  // input / array word width
  localparam int DIM_W  = 5;   // kernel dimension K
  localparam int SQ_W   = 10;  // K*K
  localparam int WCNT_W = 9;   // words per column
  localparam int NCOL_W = 6;   // active column count N

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } wlc_state_t;

  // K*K; the largest legal K (31) gives 961, which fits in SQ_W bits.
  function automatic logic [SQ_W-1:0] dim_sq(input logic [DIM_W-1:0] k);
    return SQ_W'(k) * SQ_W'(k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : weight_load_ctrl_if
// Description : Bundles the job-control, weight-stream and array-side signals
//               of weight_load_ctrl.
//               master : job issuer / stream source / observer
//               slave  : the controller
//   start, weight_dim, num_cols     job request and configuration
//   s_valid, s_data, s_ready        input weight-word stream
//   fifo_en, weight_word            column FIFO write port
//   out_en                          per-column PE feed enables
//   busy, done, err, stall_cnt      status
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_load_ctrl_if
  import weight_ctrl_pkg::*;
#(
  parameter int COL = 32
);
  logic              start;
  logic [DIM_W-1:0]  weight_dim;
  logic [NCOL_W-1:0] num_cols;
  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;
  logic [COL-1:0]    fifo_en;
  logic [WORD_W-1:0] weight_word;
  logic [COL-1:0]    out_en;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       stall_cnt;

  modport master (
    output start, weight_dim, num_cols, s_valid, s_data,
    input  s_ready, fifo_en, weight_word, out_en, busy, done, err, stall_cnt
  );

  modport slave (
    input  start, weight_dim, num_cols, s_valid, s_data,
    output s_ready, fifo_en, weight_word, out_en, busy, done, err, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pe_en_skew.sv
`default_nettype none
// ============================================================================
// Module      : pe_en_skew
// Description : Stream counter and diagonal window compare. While run is
//               high, t counts 0,1,2,...; column c is enabled when
//               c <= t < c+K*K and c < N, giving a one-cycle skew per column.
//   clk, nrst  clock, synchronous active-high reset
//   run        high for every STREAM cycle
//   kk, n      K*K and active column count of the current job
//   out_en     registered per-column enables
//   last       high during the cycle in which t = K*K+N-2
// Revision    : 1.0 - initial release
// ============================================================================
module pe_en_skew
  import weight_ctrl_pkg::*;
#(
  parameter int COL = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              run,
  input  logic [SQ_W-1:0]   kk,
  input  logic [NCOL_W-1:0] n,
  output logic [COL-1:0]    out_en,
  output logic              last
);

  // One extra bit so t and c+K*K never wrap (max 31+961 = 992).
  localparam int T_W = SQ_W + 1;

  logic [T_W-1:0] t_q, t_d;
  logic [COL-1:0] out_en_q, out_en_d;
  logic [T_W-1:0] t_last;

  assign t_last = T_W'(kk) + T_W'(n) - T_W'(2);
  assign last   = run && (t_q == t_last);

  always_comb begin
    t_d = '0;
    if (run) t_d = t_q + T_W'(1);
  end

  for (genvar c = 0; c < COL; c++) begin : g_col
    assign out_en_d[c] = run
                      && (T_W'(c) <= t_q)
                      && (t_q < (T_W'(c) + T_W'(kk)))
                      && (NCOL_W'(c) < n);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      t_q      <= '0;
      out_en_q <= '0;
    end else begin
      t_q      <= t_d;
      out_en_q <= out_en_d;
    end
  end

  assign out_en = out_en_q;

endmodule
`default_nettype wire

// File: rtl/weight_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : weight_load_ctrl
// Description : Weight FIFO sequencer. Accepts 32-bit weight words, steers
//               (K*K+1)/2 consecutive words into each of N column FIFOs via
//               one-hot fifo_en, then drives skewed per-column out_en for
//               K*K+N-1 cycles and pulses done.
//   clk, nrst   clock, synchronous active-high reset
//   bus         weight_load_ctrl_if.slave (job control, stream, array, status)
// Optional    : `WEIGHT_LOAD_CTRL_PERF_EN builds the load-phase starvation
//               counter behind stall_cnt; otherwise stall_cnt is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_load_ctrl
  import weight_ctrl_pkg::*;
#(
  parameter int COL        = 32,
  parameter int DATA_WIDTH = 16
) (
  input logic               clk,
  input logic               nrst,
  weight_load_ctrl_if.slave bus
);

  // Weights packed per input word; K*K weights need ceil(K*K/WPW) words.
  localparam int WPW = WORD_W / DATA_WIDTH;

  wlc_state_t        state_q, state_d;
  logic [WCNT_W-1:0] w_q, w_d;
  logic [NCOL_W-1:0] c_q, c_d;
  logic [WCNT_W-1:0] words_q, words_d;
  logic [SQ_W-1:0]   sq_q, sq_d;
  logic [NCOL_W-1:0] n_q, n_d;
  logic [COL-1:0]    fifo_en_q, fifo_en_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              cfg_ok;
  logic              start_acc;
  logic [SQ_W-1:0]   start_sq;
  logic [WCNT_W-1:0] start_words;
  logic              stream_last;

  assign cfg_ok      = (bus.weight_dim != '0) && (bus.num_cols != '0)
                    && (int'(bus.num_cols) <= COL);
  assign start_acc   = (state_q == IDLE) && bus.start && cfg_ok;
  assign start_sq    = dim_sq(bus.weight_dim);
  assign start_words = WCNT_W'((int'(start_sq) + WPW - 1) / WPW);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    c_d       = c_q;
    words_d   = words_q;
    sq_d      = sq_q;
    n_d       = n_q;
    fifo_en_d = '0;
    word_d    = word_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            state_d = LOAD;
            sq_d    = start_sq;
            n_d     = bus.num_cols;
            words_d = start_words;
            w_d     = '0;
            c_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // s_ready is high for all of LOAD, so s_valid alone is the handshake.
        if (bus.s_valid) begin
          fifo_en_d = COL'(1) << c_q;
          word_d    = bus.s_data;
          if (w_q == words_q - WCNT_W'(1)) begin
            w_d = '0;
            c_d = c_q + NCOL_W'(1);
            if (c_q == n_q - NCOL_W'(1)) begin
              state_d = STREAM;
              c_d     = '0;
            end
          end else begin
            w_d = w_q + WCNT_W'(1);
          end
        end
      end
      STREAM: begin
        if (stream_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        // Registered so the pulse lands one cycle after the last out_en.
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      c_q       <= '0;
      words_q   <= '0;
      sq_q      <= '0;
      n_q       <= '0;
      fifo_en_q <= '0;
      word_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      c_q       <= c_d;
      words_q   <= words_d;
      sq_q      <= sq_d;
      n_q       <= n_d;
      fifo_en_q <= fifo_en_d;
      word_q    <= word_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  pe_en_skew #(
    .COL (COL)
  ) u_skew (
    .clk    (clk),
    .nrst   (nrst),
    .run    (state_q == STREAM),
    .kk     (sq_q),
    .n      (n_q),
    .out_en (bus.out_en),
    .last   (stream_last)
  );

`ifdef WEIGHT_LOAD_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if ((state_q == LOAD) && !bus.s_valid && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.s_ready     = (state_q == LOAD);
  assign bus.busy        = (state_q != IDLE);
  assign bus.fifo_en     = fifo_en_q;
  assign bus.weight_word = word_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_load_ctrl
// Description : Self-checking bench for weight_load_ctrl. Expected behaviour
//               is computed per job from K and N with plain arithmetic:
//               accepted word i belongs to column i / ceil(K*K/2), and column
//               c is enabled t cycles into the stream when c <= t < c+K*K.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_load_ctrl;

  logic clk;
  logic nrst;
  int   checks = 0;
  int   errors = 0;

  weight_load_ctrl_if #(.COL(32)) bus ();

  weight_load_ctrl #(
    .COL        (32),
    .DATA_WIDTH (16)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".s_ready"},     64'(bus.s_ready),     64'd0);
    chk({tag, ".fifo_en"},     64'(bus.fifo_en),     64'd0);
    chk({tag, ".weight_word"}, 64'(bus.weight_word), 64'd0);
    chk({tag, ".out_en"},      64'(bus.out_en),      64'd0);
    chk({tag, ".busy"},        64'(bus.busy),        64'd0);
    chk({tag, ".done"},        64'(bus.done),        64'd0);
    chk({tag, ".err"},         64'(bus.err),         64'd0);
    chk({tag, ".stall_cnt"},   64'(bus.stall_cnt),   64'd0);
  endtask

  task automatic bad_start(input int k, input int n);
    bus.start      = 1'b1;
    bus.weight_dim = 5'(k);
    bus.num_cols   = 6'(n);
    tick();
    bus.start = 1'b0;
    chk("bad.err_pulse", 64'(bus.err),     64'd1);
    chk("bad.busy",      64'(bus.busy),    64'd0);
    chk("bad.s_ready",   64'(bus.s_ready), 64'd0);
    tick();
    chk("bad.err_clear", 64'(bus.err),     64'd0);
    chk("bad.busy2",     64'(bus.busy),    64'd0);
    chk("bad.s_ready2",  64'(bus.s_ready), 64'd0);
  endtask

  // pat: 0 = s_valid always high, 1 = toggling starting high, 2 = random.
  // inj_at: accepted-word count at which a stray start (K=5) is pulsed.
  // abort_j: stream sample index at which reset is asserted (0 = never).
  task automatic run_job(input int k, input int n, input int pat,
                         input int inj_at, input int abort_j);
    int          kk, words, total, acc, stalls, cyc, t;
    bit          v, injected;
    logic [31:0] d, exp_oe, oh;
    logic [63:0] exp_stall;
    kk       = k * k;
    words    = (kk + 1) / 2;
    total    = words * n;
    acc      = 0;
    stalls   = 0;
    cyc      = 0;
    injected = 0;

    bus.start      = 1'b1;
    bus.weight_dim = 5'(k);
    bus.num_cols   = 6'(n);
    tick();
    bus.start = 1'b0;
    chk("job.busy_after_start", 64'(bus.busy), 64'd1);

    while (acc < total) begin
      chk("load.s_ready", 64'(bus.s_ready), 64'd1);
      case (pat)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      d           = $urandom;
      bus.s_valid = v;
      bus.s_data  = d;
      if (!injected && acc == inj_at) begin
        injected       = 1;
        bus.start      = 1'b1;
        bus.weight_dim = 5'd5;
      end
      tick();
      bus.start = 1'b0;
      if (v) begin
        oh = 32'd1 << (acc / words);
        chk("load.fifo_en", 64'(bus.fifo_en), 64'(oh));
        chk("load.weight_word", 64'(bus.weight_word), 64'(d));
        acc++;
      end else begin
        chk("load.fifo_en_gap", 64'(bus.fifo_en), 64'd0);
        stalls++;
      end
      chk("load.out_en", 64'(bus.out_en), 64'd0);
      chk("load.done",   64'(bus.done),   64'd0);
      cyc++;
    end

    // Sample 1 after the last handshake: state has left LOAD.
    chk("stream.s_ready_drop", 64'(bus.s_ready), 64'd0);

    for (int j = 2; j <= kk + n + 2; j++) begin
      if (j == abort_j) begin
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        chk_all_zero("abort");
        return;
      end
      bus.s_valid = 1'($urandom);
      bus.s_data  = $urandom;
      tick();
      t      = j - 2;
      exp_oe = '0;
      for (int c = 0; c < n; c++) begin
        if (c <= t && t < c + kk) exp_oe[c] = 1'b1;
      end
      chk("stream.out_en",  64'(bus.out_en),  64'(exp_oe));
      chk("stream.fifo_en", 64'(bus.fifo_en), 64'd0);
      chk("stream.done",    64'(bus.done),    64'(j == kk + n + 1));
      chk("stream.busy",    64'(bus.busy),    64'(j <= kk + n));
    end
    bus.s_valid = 1'b0;

`ifdef WEIGHT_LOAD_CTRL_PERF_EN
    exp_stall = 64'(stalls);
`else
    exp_stall = 64'd0;
`endif
    chk("job.stall_cnt", 64'(bus.stall_cnt), exp_stall);
  endtask

  initial begin
    clk            = 1'b0;
    nrst           = 1'b1;
    bus.start      = 1'b0;
    bus.weight_dim = '0;
    bus.num_cols   = '0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    tick();
    tick();
    chk_all_zero("reset");
    nrst = 1'b0;
    tick();
    chk("post_reset.busy", 64'(bus.busy), 64'd0);

    // Basic job, continuous stream, then with a toggling s_valid.
    run_job(3, 4, 0, -1, 0);
    run_job(3, 4, 1, -1, 0);

    // Illegal configurations.
    bad_start(0, 4);
    bad_start(3, 0);
    bad_start(3, 33);

    // Stray start during LOAD after 3 words must be ignored.
    run_job(3, 4, 0, 3, 0);

    // Reset during STREAM, then a K=1, N=32 job.
    run_job(3, 4, 2, -1, 6);
    run_job(1, 32, 0, -1, 0);

    // Randomised configurations and stream gaps.
    for (int r = 0; r < 4; r++) begin
      run_job(int'($urandom_range(1, 8)), int'($urandom_range(1, 32)), 2, -1, 0);
    end

    // Largest legal job.
    run_job(31, 32, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
